usb_fs_rx: RTL and testbench
============================

Name: usb_fs_rx

Overview:
- Parametrised Full-Speed receive path; the successor to the fixed line-state recovery in the UTM.
- Takes raw single-ended D+/D- from the analog frontend and synchronises and glitch-filters them.
- Recovers bit timing with an oversampling DPLL, then performs NRZI decode, SYNC detect, bit unstuffing, byte assembly and EOP detection.
- Drives the UTMI receive signals: RxActive, RxValid, RxError, DataOut and LineState.

Parameters:
- OSR, 4, clocks per FS bit time; clk = OSR*12 MHz; legal range 4..16.
- SYNC_STAGES, 2, number of synchroniser flops on dp_rx/dn_rx; must be >=2.
- FILT_LEN, 2, consecutive identical synced samples required before line_state changes; must be >=1.

Ports:
- clk  in  1  system clock, OSR*12 MHz
- rst  in  1  reset; synchronous, active-high
- dp_rx  in  1  raw D+ from frontend, asynchronous
- dn_rx  in  1  raw D- from frontend, asynchronous
- rx_en  in  1  receive enable; low while the device transmits
- line_state  out  2  filtered UTMI LineState, utmi_line_state_t
- rx_active  out  1  UTMI RxActive
- rx_valid  out  1  UTMI RxValid; one-cycle pulse per byte
- rx_data  out  8  UTMI DataOut; valid when rx_valid=1
- rx_error  out  1  UTMI RxError; one-cycle pulse

Behaviour:
Reset values:
- sync flops 0; line_state=SE0; rx_active=0; rx_valid=0; rx_data=8'h00; rx_error=0.
- FSM=RX_IDLE; phase counter 0.

Synchroniser and filter:
- {dn,dp} pass through SYNC_STAGES flops.
- line_state takes the synced value only after it has been stable and different from line_state for FILT_LEN consecutive cycles.
- Minimum latency from pin to line_state is SYNC_STAGES+FILT_LEN cycles.

DPLL:
- Phase counter runs 0..OSR-1 and wraps to 0.
- Any line_state change between J and K reloads the counter to 0 in the same cycle.
- Changes to or from SE0 do not reload.
- bit_stb asserts for one cycle when counter==OSR/2 (integer division). This gives mid-bit sampling and tolerates +-1 clk of drift per transition.

FSM (advances only on bit_stb, except for the rx_en override):
- RX_IDLE: on a sample of K, go to RX_SYNC with zero_cnt=0, prev=K.
- RX_SYNC:
  - Decoded bit is 0 if sample!=prev, 1 if sample==prev; update prev.
  - On bit 0: zero_cnt++, saturating at 7.
  - On bit 1 with zero_cnt>=SYNC_MIN_ZEROS (3): go to RX_DATA. rx_active rises on the cycle after this bit_stb. ones_cnt=1, bit_cnt=0.
  - On bit 1 with zero_cnt<3, or a sample of SE0: return to RX_IDLE with no flags.
- RX_DATA:
  - A sample of SE0 goes to RX_EOP.
  - Otherwise decode the NRZI bit.
    - If ones_cnt==STUFF_LEN (6): a bit 0 is the stuff bit; drop it and set ones_cnt=0. A bit 1 is a stuff error; pulse rx_error and go to RX_ABORT.
    - Otherwise shift the bit into the shift register LSB-first. ones_cnt increments on 1 and clears on 0. bit_cnt++.
  - When bit_cnt wraps 7->0: rx_data is loaded and rx_valid pulses exactly one cycle after the bit_stb that sampled the 8th bit.
- RX_EOP:
  - bit_cnt>=2 at SE0 entry: pulse rx_error, as a byte alignment error.
  - bit_cnt==1 is a dribble bit; discard it silently.
  - A later sample of SE0 stays in RX_EOP. A sample of J goes to RX_IDLE. A sample of K pulses rx_error and goes to RX_ABORT.
- RX_ABORT: stay until a sample of J, then go to RX_IDLE.
- rx_active is 1 exactly in RX_DATA, RX_EOP and RX_ABORT. It is registered, so it falls the cycle after entering RX_IDLE.

Override and simultaneous events:
- rx_en=0 forces RX_IDLE on the next clk from any state and suppresses rx_valid and rx_error in that cycle.
- line_state tracking continues while rx_en=0.
- rx_error and rx_valid never assert in the same cycle. If both are due together, error wins and the byte is discarded.
- A synchronous rst mid-packet returns every output to its reset value on the next edge.

Decomposition:
- usb_utmi_pkg: reuse utmi_line_state_t. Add usb_fs_rx_state_t (RX_IDLE, RX_SYNC, RX_DATA, RX_EOP, RX_ABORT). Add constants USB_FS_STUFF_LEN=6 and USB_FS_SYNC_MIN_ZEROS=3.
- Sub-module usb_fs_dpll contains the synchroniser, the FILT_LEN filter and the phase counter. It outputs line_state and bit_stb.
- The top level holds the FSM, NRZI decode, unstuffing and byte assembly.

Test Plan:
- Idle then packet: OSR=4. Sequence is SYNC, byte 8'hA5 (NRZI encoded), SE0 SE0 J.
  - rx_active rises 1 clk after the SYNC's final K bit_stb.
  - One rx_valid pulse with rx_data=8'hA5.
  - rx_active falls 1 clk after RX_IDLE is entered; rx_error is never asserted.
- Bit stuffing: SYNC, byte 8'hFF with the stuffed 0 after six 1s, then 8'h00, then EOP.
  - rx_valid twice, with data 8'hFF then 8'h00; no error.
- Stuff error: seven consecutive J-J-J... bits (no transition) after six 1s.
  - One rx_error pulse; rx_valid is never asserted for that byte.
  - rx_active stays 1 until J is sampled after SE0, then falls.
- Jitter and glitch:
  - Driving bit periods alternating 3/5 clks (OSR=4) still gives byte 8'h3C correctly.
  - A 1-clk SE1 glitch with FILT_LEN=2 does not change line_state.
- Abort and alignment:
  - EOP after 4 bits of the second byte: rx_error pulses and there is no second rx_valid.
  - EOP after 1 dribble bit: no error.
  - rx_en dropped mid-byte: rx_active=0 on the next clk and no rx_valid.
- Reset mid-packet: assert rst for 1 clk during the 3rd byte.
  - All outputs return to reset values on the next edge.
  - line_state returns to SE0.
  - A following packet decodes normally.

Source files
------------

// File: rtl/usb_utmi_pkg.sv
// Shared UTMI types and Full-Speed receive constants.
package usb_utmi_pkg;

    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_J   = 2'b01,
        LS_K   = 2'b10,
        LS_SE1 = 2'b11
    } utmi_line_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_SYNC,
        RX_DATA,
        RX_EOP,
        RX_ABORT
    } usb_fs_rx_state_t;

    localparam int unsigned USB_FS_STUFF_LEN      = 6;
    localparam int unsigned USB_FS_SYNC_MIN_ZEROS = 3;

    function automatic logic is_jk(input logic [1:0] ls);
        return (ls == LS_J) || (ls == LS_K);
    endfunction

endpackage

// File: rtl/usb_fs_dpll.sv
// Line-state recovery: pin synchroniser, stability filter and bit-timing phase counter.
module usb_fs_dpll
    import usb_utmi_pkg::*;
#(
    parameter int unsigned OSR         = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dp_rx,
    input  logic       dn_rx,
    output logic [1:0] line_state,
    output logic       bit_stb
);

    localparam int unsigned SYNC_W = 2 * SYNC_STAGES;
    localparam int unsigned CNT_W  = $clog2(FILT_LEN + 1);
    localparam int unsigned PH_W   = $clog2(OSR);

    logic [SYNC_W-1:0] sync_q;
    logic [1:0]        synced;
    logic [1:0]        cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, run;
    logic [1:0]        ls_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              jk_change;

    assign synced = sync_q[SYNC_W-1 -: 2];
    assign run    = (synced == cand_q) ? cnt_q + CNT_W'(1) : CNT_W'(1);

    // Accept a new line state only after FILT_LEN identical differing samples
    always_comb begin
        ls_d   = line_state;
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (synced == line_state) begin
            cnt_d = '0;
        end else if (run >= CNT_W'(FILT_LEN)) begin
            ls_d  = synced;
            cnt_d = '0;
        end else begin
            cand_d = synced;
            cnt_d  = run;
        end
    end

    // Only J<->K edges carry timing; SE0 edges leave the phase alone
    always_comb begin
        jk_change = is_jk(ls_d) && is_jk(line_state) && (ls_d != line_state);
        if (jk_change || (phase_q == PH_W'(OSR - 1))) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + PH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            cand_q     <= LS_SE0;
            cnt_q      <= '0;
            line_state <= LS_SE0;
            phase_q    <= '0;
            bit_stb    <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_W-3:0], dn_rx, dp_rx};
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            line_state <= ls_d;
            phase_q    <= phase_d;
            bit_stb    <= (phase_d == PH_W'(OSR / 2));
        end
    end

endmodule

// File: rtl/usb_fs_rx.sv
// Full-Speed receive path: NRZI decode, SYNC/EOP detection, unstuffing and byte assembly.
module usb_fs_rx
    import usb_utmi_pkg::*;
#(
    parameter int unsigned OSR         = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dp_rx,
    input  logic       dn_rx,
    input  logic       rx_en,
    output logic [1:0] line_state,
    output logic       rx_active,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_error
);

    usb_fs_rx_state_t state_q, state_d;
    logic [1:0] prev_q, prev_d;
    logic [2:0] zero_q, zero_d;
    logic [2:0] ones_q, ones_d;
    logic [2:0] bitc_q, bitc_d;
    logic [7:0] shreg_q, shreg_d;
    logic       bit_stb;
    logic       nrzi_bit;
    logic       byte_done;
    logic       err_evt;
    logic       rx_active_d, rx_valid_d, rx_error_d;
    logic [7:0] rx_data_d;

    usb_fs_dpll #(
        .OSR        (OSR),
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) u_dpll (
        .clk       (clk),
        .rst       (rst),
        .dp_rx     (dp_rx),
        .dn_rx     (dn_rx),
        .line_state(line_state),
        .bit_stb   (bit_stb)
    );

    assign nrzi_bit = (line_state == prev_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RX_IDLE;
            prev_q    <= LS_SE0;
            zero_q    <= '0;
            ones_q    <= '0;
            bitc_q    <= '0;
            shreg_q   <= '0;
            rx_active <= 1'b0;
            rx_valid  <= 1'b0;
            rx_data   <= 8'h00;
            rx_error  <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            zero_q    <= zero_d;
            ones_q    <= ones_d;
            bitc_q    <= bitc_d;
            shreg_q   <= shreg_d;
            rx_active <= rx_active_d;
            rx_valid  <= rx_valid_d;
            rx_data   <= rx_data_d;
            rx_error  <= rx_error_d;
        end
    end

    // Next state and datapath, advanced once per recovered bit
    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        zero_d    = zero_q;
        ones_d    = ones_q;
        bitc_d    = bitc_q;
        shreg_d   = shreg_q;
        byte_done = 1'b0;
        err_evt   = 1'b0;
        if (bit_stb) begin
            unique case (state_q)
                RX_IDLE: begin
                    if (line_state == LS_K) begin
                        state_d = RX_SYNC;
                        zero_d  = '0;
                        prev_d  = LS_K;
                    end
                end
                RX_SYNC: begin
                    if (line_state == LS_SE0) begin
                        state_d = RX_IDLE;
                    end else begin
                        prev_d = line_state;
                        if (!nrzi_bit) begin
                            if (zero_q != 3'd7) zero_d = zero_q + 3'd1;
                        end else if (zero_q >= 3'(USB_FS_SYNC_MIN_ZEROS)) begin
                            state_d = RX_DATA;
                            ones_d  = 3'd1;
                            bitc_d  = '0;
                        end else begin
                            state_d = RX_IDLE;
                        end
                    end
                end
                RX_DATA: begin
                    if (line_state == LS_SE0) begin
                        state_d = RX_EOP;
                        err_evt = (bitc_q >= 3'd2);
                    end else begin
                        prev_d = line_state;
                        if (ones_q == 3'(USB_FS_STUFF_LEN)) begin
                            if (nrzi_bit) begin
                                err_evt = 1'b1;
                                state_d = RX_ABORT;
                            end else begin
                                ones_d = '0;
                            end
                        end else begin
                            shreg_d   = {nrzi_bit, shreg_q[7:1]};
                            ones_d    = nrzi_bit ? ones_q + 3'd1 : 3'd0;
                            bitc_d    = bitc_q + 3'd1;
                            byte_done = (bitc_q == 3'd7);
                        end
                    end
                end
                RX_EOP: begin
                    if (line_state == LS_J) begin
                        state_d = RX_IDLE;
                    end else if (line_state == LS_K) begin
                        err_evt = 1'b1;
                        state_d = RX_ABORT;
                    end
                end
                RX_ABORT: begin
                    if (line_state == LS_J) state_d = RX_IDLE;
                end
                default: state_d = RX_IDLE;
            endcase
        end
        if (!rx_en) state_d = RX_IDLE;
    end

    // Output next values; an error always discards a coincident byte
    always_comb begin
        rx_error_d  = err_evt & rx_en;
        rx_valid_d  = byte_done & rx_en & ~err_evt;
        rx_data_d   = rx_valid_d ? shreg_d : rx_data;
        rx_active_d = (state_d == RX_DATA) || (state_d == RX_EOP) || (state_d == RX_ABORT);
    end

endmodule

// File: tb/tb_usb_fs_rx.sv
// Scoreboard bench for usb_fs_rx: NRZI/stuffing encoder drives pins, monitor pops expected bytes.
module tb_usb_fs_rx;

    localparam int unsigned OSR         = 4;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned FILT_LEN    = 2;
    localparam int unsigned RISE_LAT    = SYNC_STAGES + FILT_LEN + OSR / 2 + 1 + OSR;
    localparam logic [1:0] J   = 2'b01;
    localparam logic [1:0] K   = 2'b10;
    localparam logic [1:0] SE0 = 2'b00;
    localparam logic [1:0] SE1 = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       dp_rx, dn_rx, rx_en;
    logic [1:0] line_state;
    logic       rx_active, rx_valid, rx_error;
    logic [7:0] rx_data;

    int         n_cmp = 0;
    int         n_mis = 0;
    int         cyc = 0;
    int         err_seen = 0;
    int         sync_mark = 0;
    int         rise_cyc = 0;
    int         ones = 0;
    logic [1:0] cur = 2'b01;
    logic       jit = 1'b0;
    logic       jt = 1'b0;
    logic       act_prev = 1'b0;
    logic [7:0] exp_q[$];

    usb_fs_rx #(
        .OSR        (OSR),
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dp_rx     (dp_rx),
        .dn_rx     (dn_rx),
        .rx_en     (rx_en),
        .line_state(line_state),
        .rx_active (rx_active),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_error  (rx_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // Monitor: pop scoreboard on each byte, tally error pulses, note rx_active rise
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                if (exp_q.size() == 0) check("unexp_valid", 32'(rx_valid), 32'd0);
                else check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
            if (rx_error) begin
                err_seen++;
                check("err_excl_valid", 32'(rx_valid), 32'd0);
            end
            if (rx_active && !act_prev) rise_cyc = cyc;
        end
        act_prev = rx_active;
    end

    task automatic drive(input logic [1:0] ls, input int n);
        {dn_rx, dp_rx} = ls;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic [1:0] ls);
        int n;
        n  = jit ? (jt ? 5 : 3) : int'(OSR);
        jt = ~jt;
        drive(ls, n);
    endtask

    task automatic send_raw(input logic b);
        if (!b) cur = (cur == J) ? K : J;
        drive_bit(cur);
        ones = b ? ones + 1 : 0;
    endtask

    task automatic send_bit(input logic b);
        send_raw(b);
        if (ones == 6) send_raw(1'b0);
    endtask

    task automatic send_sync();
        cur = J;
        for (int i = 0; i < 8; i++) begin
            if (i == 6) sync_mark = cyc;
            send_raw(i == 7);
        end
    endtask

    task automatic send_bits(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) send_bit(d[i]);
    endtask

    task automatic send_byte(input logic [7:0] d);
        exp_q.push_back(d);
        send_bits(d, 8);
    endtask

    task automatic idle(input int n);
        cur = J;
        repeat (n) drive_bit(J);
    endtask

    task automatic send_eop();
        drive_bit(SE0);
        drive_bit(SE0);
        idle(8);
    endtask

    task automatic end_packet(input string tag, input int exp_err);
        idle(4);
        check({tag, "_err_cnt"}, 32'(err_seen), 32'(exp_err));
        err_seen = 0;
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_active_idle"}, 32'(rx_active), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        rx_en = 1'b1;
        {dn_rx, dp_rx} = J;
        repeat (3) @(negedge clk);
        check("rst_line_state", 32'(line_state), 32'(SE0));
        check("rst_active", 32'(rx_active), 32'd0);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data", 32'(rx_data), 32'd0);
        check("rst_error", 32'(rx_error), 32'd0);
        rst = 1'b0;
        for (int i = 1; i <= int'(SYNC_STAGES + FILT_LEN); i++) begin
            @(negedge clk);
            check("ls_latency", 32'(line_state), (i < int'(SYNC_STAGES + FILT_LEN)) ? 32'(SE0) : 32'(J));
        end
        idle(4);

        // Basic packet
        send_sync();
        send_byte(8'hA5);
        send_eop();
        check("t1_rise_lat", 32'(rise_cyc - sync_mark), 32'(RISE_LAT));
        end_packet("t1", 0);

        // Bit stuffing
        send_sync();
        send_byte(8'hFF);
        send_byte(8'h00);
        send_eop();
        check("t2_rise_lat", 32'(rise_cyc - sync_mark), 32'(RISE_LAT));
        end_packet("t2", 0);

        // Stuff error: no transition where a stuff bit is due
        send_sync();
        repeat (7) send_raw(1'b1);
        check("t3_active_abort", 32'(rx_active), 32'd1);
        send_eop();
        end_packet("t3", 1);

        // Jittered bit periods
        jit = 1'b1;
        send_sync();
        send_byte(8'h3C);
        send_eop();
        end_packet("t4", 0);
        jit = 1'b0;

        // One-clock SE1 glitch
        {dn_rx, dp_rx} = SE1;
        @(negedge clk);
        {dn_rx, dp_rx} = J;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t5_glitch_ls", 32'(line_state), 32'(J));
        end
        end_packet("t5", 0);

        // Byte alignment error
        send_sync();
        send_byte(8'h5A);
        send_bits(8'h0F, 4);
        send_eop();
        end_packet("t6", 1);

        // Dribble bit
        send_sync();
        send_byte(8'hC3);
        send_bits(8'h01, 1);
        send_eop();
        end_packet("t7", 0);

        // rx_en dropped mid-byte
        send_sync();
        send_byte(8'h96);
        send_bits(8'h55, 3);
        check("t8_pre_active", 32'(rx_active), 32'd1);
        rx_en = 1'b0;
        @(negedge clk);
        check("t8_drop_active", 32'(rx_active), 32'd0);
        send_bits(8'hAA, 3);
        send_eop();
        check("t8_ls_track", 32'(line_state), 32'(J));
        rx_en = 1'b1;
        end_packet("t8", 0);

        // Reset during the third byte, then a clean packet
        send_sync();
        send_byte(8'h12);
        send_byte(8'h34);
        send_bits(8'h56, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t9_rst_line_state", 32'(line_state), 32'(SE0));
        check("t9_rst_active", 32'(rx_active), 32'd0);
        check("t9_rst_valid", 32'(rx_valid), 32'd0);
        check("t9_rst_data", 32'(rx_data), 32'd0);
        check("t9_rst_error", 32'(rx_error), 32'd0);
        idle(12);
        end_packet("t9", 0);
        send_sync();
        send_byte(8'h78);
        send_eop();
        check("t9b_rise_lat", 32'(rise_cyc - sync_mark), 32'(RISE_LAT));
        end_packet("t9b", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
